// File: rtl/config_read_fifo_pkg.sv
// -----------------------------------------------------------------------------
// config_read_fifo_pkg
// Shared config-bus definitions for the readback FIFO:
//   - CONF_DATA_W / CONF_ADDR_W : config register bus widths
//   - OFS_*                     : register offsets relative to the block base
//   - EMPTY_CNT_W               : width of the saturating empty-read counter
//   - reg_sel_e / decode_sel()  : which local register a request hits, if any
// -----------------------------------------------------------------------------
package config_read_fifo_pkg;

  localparam int CONF_DATA_W = 64;
  localparam int CONF_ADDR_W = 16;
  localparam int EMPTY_CNT_W = 32;

  localparam logic [CONF_ADDR_W-1:0] OFS_DATA      = CONF_ADDR_W'(0);
  localparam logic [CONF_ADDR_W-1:0] OFS_LEVEL     = CONF_ADDR_W'(1);
  localparam logic [CONF_ADDR_W-1:0] OFS_EMPTY_CNT = CONF_ADDR_W'(2);

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_DATA,
    SEL_LEVEL,
    SEL_EMPTY_CNT
  } reg_sel_e;

  // Offset is taken modulo the address width, so an address below the base
  // wraps to a large offset and never hits.
  function automatic reg_sel_e decode_sel(
    input logic                   valid,
    input logic [CONF_ADDR_W-1:0] addr,
    input logic [CONF_ADDR_W-1:0] base
  );
    logic [CONF_ADDR_W-1:0] ofs;
    ofs = addr - base;
    if (!valid) return SEL_NONE;
    if (ofs == OFS_DATA) return SEL_DATA;
    if (ofs == OFS_LEVEL) return SEL_LEVEL;
    if (ofs == OFS_EMPTY_CNT) return SEL_EMPTY_CNT;
    return SEL_NONE;
  endfunction

endpackage

// File: rtl/ready_valid_i.sv
// -----------------------------------------------------------------------------
// ready_valid_i
// Generic ready/valid stream carrying one data_t per handshake.
//   data  : payload
//   valid : producer has a payload
//   ready : consumer accepts the payload this cycle
// Modport s is the sink (consumer) side.
// -----------------------------------------------------------------------------
interface ready_valid_i #(
  parameter type data_t = logic [7:0]
);
  data_t data;
  logic  valid;
  logic  ready;

  modport s (input data, input valid, output ready);
  modport m (output data, output valid, input ready);
endinterface

// File: rtl/config_read_fifo_fifo.sv
// -----------------------------------------------------------------------------
// config_read_fifo_fifo
// Power-of-two depth FIFO with a combinational head view.
//   clk, rst_n        : clock, asynchronous active-low reset
//   i_data/i_valid    : push side; i_ready = not full (from registered level)
//   o_data/o_valid    : head entry and non-empty flag
//   o_ready           : pop request; pops only when o_valid
//   o_filling_level   : registered entry count, 0..DEPTH
// -----------------------------------------------------------------------------
module config_read_fifo_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_valid,
  output logic                       i_ready,
  output logic [WIDTH-1:0]           o_data,
  output logic                       o_valid,
  input  logic                       o_ready,
  output logic [$clog2(DEPTH+1)-1:0] o_filling_level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH+1);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [LVL_W-1:0] level_reg, level_next;
  logic             push, pop;

  assign i_ready = (level_reg != FULL_LVL);
  assign o_valid = (level_reg != '0);
  assign o_data  = mem[rd_ptr_reg];
  assign o_filling_level = level_reg;

  assign push = i_valid && i_ready;
  assign pop  = o_ready && o_valid;

  always_comb begin
    level_next = level_reg;
    unique case ({push, pop})
      2'b10:   level_next = level_reg + LVL_W'(1);
      2'b01:   level_next = level_reg - LVL_W'(1);
      default: level_next = level_reg;
    endcase
  end

  // Storage carries no reset; stale contents are unreachable once the
  // pointers and level are cleared.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= i_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      level_reg <= level_next;
    end
  end

endmodule

// File: rtl/config_read_fifo.sv
// -----------------------------------------------------------------------------
// config_read_fifo
// Buffers a datapath ready/valid stream and lets the host drain it through
// config register reads.
//   clk, rst_n      : clock, asynchronous active-low reset
//   data            : input stream (sink side)
//   rd_req_valid    : config read strobe, one cycle per request
//   rd_req_addr     : config read address
//   rd_resp_valid   : one-cycle response strobe, 1 cycle after a hit
//   rd_resp_data    : response data
// Registers: ADDR = pop head ({valid flag, zero pad, entry}, or 0 if empty),
// ADDR+1 = fill level, ADDR+2 = saturating empty-read count (read-to-clear).
// -----------------------------------------------------------------------------
module config_read_fifo
  import config_read_fifo_pkg::*;
#(
  parameter logic [CONF_ADDR_W-1:0] ADDR   = CONF_ADDR_W'(0),
  parameter int                     DEPTH  = 4,
  parameter type                    data_t = logic [7:0]
) (
  input  logic                   clk,
  input  logic                   rst_n,
  ready_valid_i.s                data,
  input  logic                   rd_req_valid,
  input  logic [CONF_ADDR_W-1:0] rd_req_addr,
  output logic                   rd_resp_valid,
  output logic [CONF_DATA_W-1:0] rd_resp_data
);

  localparam int DW    = $bits(data_t);
  localparam int LVL_W = $clog2(DEPTH+1);

  if (DW > CONF_DATA_W-1) begin : g_width_check
    $error("config_read_fifo: data_t wider than CONF_DATA_W-1");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH-1)) != 0) begin : g_depth_check
    $error("config_read_fifo: DEPTH must be a power of two >= 2");
  end

  reg_sel_e                sel;
  logic                    pop;
  logic                    fifo_in_ready;
  logic                    head_valid;
  data_t                   head;
  logic [LVL_W-1:0]        level;
  logic [EMPTY_CNT_W-1:0]  empty_cnt_reg, empty_cnt_next;
  logic                    resp_valid_reg;
  logic [CONF_DATA_W-1:0]  resp_data_reg, resp_data_next;
  logic [CONF_DATA_W-1:0]  entry_word;

  assign sel = decode_sel(rd_req_valid, rd_req_addr, ADDR);
  assign pop = (sel == SEL_DATA);

  // Held low during reset so the producer never sees a phantom slot.
  assign data.ready = rst_n && fifo_in_ready;

  config_read_fifo_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DW)
  ) u_fifo (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_data          (data.data),
    .i_valid         (data.valid),
    .i_ready         (fifo_in_ready),
    .o_data          (head),
    .o_valid         (head_valid),
    .o_ready         (pop),
    .o_filling_level (level)
  );

  always_comb begin
    entry_word = '0;
    entry_word[DW-1:0] = head;
    entry_word[CONF_DATA_W-1] = 1'b1;

    resp_data_next = '0;
    unique case (sel)
      SEL_DATA:      if (head_valid) resp_data_next = entry_word;
      SEL_LEVEL:     resp_data_next = CONF_DATA_W'(level);
      SEL_EMPTY_CNT: resp_data_next = CONF_DATA_W'(empty_cnt_reg);
      default:       resp_data_next = '0;
    endcase
  end

  always_comb begin
    empty_cnt_next = empty_cnt_reg;
    if (sel == SEL_EMPTY_CNT)
      empty_cnt_next = '0;
    else if (sel == SEL_DATA && !head_valid && empty_cnt_reg != '1)
      empty_cnt_next = empty_cnt_reg + EMPTY_CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid_reg <= 1'b0;
      resp_data_reg  <= '0;
      empty_cnt_reg  <= '0;
    end else begin
      resp_valid_reg <= (sel != SEL_NONE);
      resp_data_reg  <= resp_data_next;
      empty_cnt_reg  <= empty_cnt_next;
    end
  end

  assign rd_resp_valid = resp_valid_reg;
  assign rd_resp_data  = resp_data_reg;

endmodule
